simon_input_conditioner: RTL and testbench

Upstream stage of the Simon game core. It takes four raw, bouncy, asynchronous push-buttons and produces a clean, debounced, single-button press for the core: a 2-bit colour index plus a press level. It runs on the same 60 Hz game clock. It locks out player input while Simon is playing its sequence, and rejects multi-button presses.

---
 rtl/simon_input_conditioner_if.sv | 43 ++++
 rtl/simon_input_conditioner.sv | 205 ++++++++++++++++++++
 tb/tb_simon_input_conditioner.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// simon_input_conditioner_if
//
// Groups the signals that run between the raw button/game-core side and the
// Simon input conditioner.
//
//   btn[3:0]       raw push-buttons, active-high, btn[i] is colour i
//   simonTurn      high while the game core owns the turn (input lockout)
//   playerNum[1:0] colour index of the accepted button
//   playerPressed  level, high while the accepted press is held
//   pressEvent     one-cycle pulse when playerPressed rises
//   multiPress     level, high while a rejected press is being held
//
// Modports:
//   master - the side that supplies buttons/lockout and observes the result
//   slave  - the conditioner itself
// ---------------------------------------------------------------------------
interface simon_input_conditioner_if;
  logic [3:0] btn;
  logic       simonTurn;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic       pressEvent;
  logic       multiPress;

  modport master (
    output btn,
    output simonTurn,
    input  playerNum,
    input  playerPressed,
    input  pressEvent,
    input  multiPress
  );

  modport slave (
    input  btn,
    input  simonTurn,
    output playerNum,
    output playerPressed,
    output pressEvent,
    output multiPress
  );
endinterface

// File: rtl/simon_input_conditioner.sv
// ---------------------------------------------------------------------------
// simon_input_conditioner
//
// Upstream stage of the Simon game core. Takes four raw, bouncy, asynchronous
// push-buttons and turns them into one clean single-button press: a 2-bit
// colour index plus a press level and a one-cycle press pulse. Player input
// is locked out while simonTurn is high, and presses of more than one button
// are rejected until every button has been released.
//
// Parameters:
//   DEBOUNCE_TICKS  consecutive clk cycles a synchronized button must differ
//                   from its debounced state before that state flips (1..15)
//
// Ports:
//   clk    game clock (60 Hz), rising edge
//   reset  asynchronous, active-high, clears all state and outputs
//   bus    simon_input_conditioner_if.slave
//            in : btn[3:0], simonTurn
//            out: playerNum[1:0], playerPressed, pressEvent, multiPress
//
// Latency from a raw button edge to playerPressed is DEBOUNCE_TICKS+3 clock
// edges: two for the synchronizer, DEBOUNCE_TICKS for the debouncer and one
// for the registered FSM outputs. Release takes the same path.
// ---------------------------------------------------------------------------
module simon_input_conditioner #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input logic                          clk,
  input logic                          reset,
  simon_input_conditioner_if.slave     bus
);

  localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REJECT = 2'd2
  } stateT;

  // Synchronizer and debouncer storage
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;
  logic [3:0] debCnt [4];

  // FSM state and registered outputs
  stateT      state;
  stateT      stateNext;
  logic [1:0] playerNumReg;
  logic [1:0] playerNumNext;
  logic       playerPressedReg;
  logic       playerPressedNext;
  logic       pressEventReg;
  logic       pressEventNext;
  logic       multiPressReg;
  logic       multiPressNext;

  // Decoded view of the debounced vector
  logic       singleHot;
  logic [1:0] hotIndex;

  // Two-flop synchronizer per button. The buttons are fully asynchronous to
  // the game clock, so only sync2 is ever looked at by the rest of the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
    end
  end

  // Per-button debouncer. The counter only runs while the synchronized value
  // disagrees with the debounced value; any agreement restarts it, so a
  // glitch shorter than DEBOUNCE_TICKS cycles never reaches deb. The flip
  // happens on the cycle the counter would reach DEBOUNCE_TICKS, which keeps
  // the press and release paths symmetric.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        debCnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          debCnt[i] <= 4'd0;
        end else if ((debCnt[i] + 4'd1) == TICKS) begin
          deb[i]    <= sync2[i];
          debCnt[i] <= 4'd0;
        end else begin
          debCnt[i] <= debCnt[i] + 4'd1;
        end
      end
    end
  end

  // A press is only acceptable when exactly one debounced bit is set.
  // x & (x-1) clears the lowest set bit, so it is zero only for one-hot x.
  always_comb begin
    singleHot = (deb != 4'b0000) && ((deb & (deb - 4'd1)) == 4'b0000);
  end

  // Colour index of the single set bit; only used when singleHot is true.
  always_comb begin
    case (deb)
      4'b0001: hotIndex = 2'd0;
      4'b0010: hotIndex = 2'd1;
      4'b0100: hotIndex = 2'd2;
      4'b1000: hotIndex = 2'd3;
      default: hotIndex = 2'd0;
    endcase
  end

  // State register and registered outputs, all updated together so the
  // outputs always describe the state just entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      playerNumReg     <= 2'd0;
      playerPressedReg <= 1'b0;
      pressEventReg    <= 1'b0;
      multiPressReg    <= 1'b0;
    end else begin
      state            <= stateNext;
      playerNumReg     <= playerNumNext;
      playerPressedReg <= playerPressedNext;
      pressEventReg    <= pressEventNext;
      multiPressReg    <= multiPressNext;
    end
  end

  // Next-state and next-output logic. The lockout is tested before the
  // one-hot check in IDLE so that a button settling on the same cycle
  // simonTurn rises is rejected. playerNum keeps its last accepted value
  // outside PRESS, and pressEvent defaults low so it can only pulse on the
  // IDLE->PRESS transition. Once in PRESS, extra or switched buttons are
  // ignored until everything is released; REJECT is left only when all
  // buttons are up, whatever simonTurn is doing.
  always_comb begin
    stateNext         = state;
    playerNumNext     = playerNumReg;
    playerPressedNext = playerPressedReg;
    pressEventNext    = 1'b0;
    multiPressNext    = multiPressReg;

    case (state)
      IDLE: begin
        playerPressedNext = 1'b0;
        multiPressNext    = 1'b0;
        if (deb == 4'b0000) begin
          stateNext = IDLE;
        end else if (bus.simonTurn) begin
          stateNext      = REJECT;
          multiPressNext = 1'b1;
        end else if (singleHot) begin
          stateNext         = PRESS;
          playerNumNext     = hotIndex;
          playerPressedNext = 1'b1;
          pressEventNext    = 1'b1;
        end else begin
          stateNext      = REJECT;
          multiPressNext = 1'b1;
        end
      end

      PRESS: begin
        playerPressedNext = 1'b1;
        multiPressNext    = 1'b0;
        if (bus.simonTurn) begin
          stateNext         = REJECT;
          playerPressedNext = 1'b0;
          multiPressNext    = 1'b1;
        end else if (deb == 4'b0000) begin
          stateNext         = IDLE;
          playerPressedNext = 1'b0;
        end
      end

      REJECT: begin
        playerPressedNext = 1'b0;
        multiPressNext    = 1'b1;
        if (deb == 4'b0000) begin
          stateNext      = IDLE;
          multiPressNext = 1'b0;
        end
      end

      default: begin
        stateNext         = IDLE;
        playerPressedNext = 1'b0;
        multiPressNext    = 1'b0;
      end
    endcase
  end

  // Drive the interface outputs from the registers.
  assign bus.playerNum     = playerNumReg;
  assign bus.playerPressed = playerPressedReg;
  assign bus.pressEvent    = pressEventReg;
  assign bus.multiPress    = multiPressReg;

endmodule

// File: tb/tb_simon_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_simon_input_conditioner
//
// Directed bench for simon_input_conditioner. A behavioural model tracks the
// expected outputs every cycle; the directed sequences additionally pin
// edge-exact latencies and literal output values.
// ---------------------------------------------------------------------------
module tb_simon_input_conditioner;

  localparam int DT = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  simon_input_conditioner_if bus();

  simon_input_conditioner #(
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  localparam int M_IDLE   = 0;
  localparam int M_PRESS  = 1;
  localparam int M_REJECT = 2;

  logic [3:0] mS1;
  logic [3:0] mS2;
  logic [3:0] mDeb;
  logic [3:0] seen [$];
  int         mMode;
  logic [1:0] expNum;
  logic       expPressed;
  logic       expEvent;
  logic       expMulti;

  // The model treats the synchronizer as a two-cycle delay line and the
  // debouncer as a sliding window: a debounced bit flips when the last DT
  // synchronized samples all disagree with it.
  always @(posedge clk or posedge reset) begin
    logic [3:0] newDeb;
    logic       allDiff;
    if (reset) begin
      mS1 = 4'b0; mS2 = 4'b0; mDeb = 4'b0;
      seen.delete();
      mMode = M_IDLE;
      expNum = 2'd0; expPressed = 1'b0; expEvent = 1'b0; expMulti = 1'b0;
    end else begin
      expEvent = 1'b0;
      case (mMode)
        M_IDLE: begin
          if (mDeb != 4'b0) begin
            if (bus.simonTurn || $countones(mDeb) != 1) begin
              mMode = M_REJECT; expMulti = 1'b1;
            end else begin
              mMode = M_PRESS; expPressed = 1'b1; expEvent = 1'b1;
              for (int i = 0; i < 4; i++) if (mDeb[i]) expNum = 2'(i);
            end
          end
        end
        M_PRESS: begin
          if (bus.simonTurn) begin
            mMode = M_REJECT; expPressed = 1'b0; expMulti = 1'b1;
          end else if (mDeb == 4'b0) begin
            mMode = M_IDLE; expPressed = 1'b0;
          end
        end
        default: begin
          if (mDeb == 4'b0) begin
            mMode = M_IDLE; expMulti = 1'b0;
          end
        end
      endcase

      seen.push_back(mS2);
      if (seen.size() > DT) void'(seen.pop_front());
      newDeb = mDeb;
      if (seen.size() == DT) begin
        for (int i = 0; i < 4; i++) begin
          allDiff = 1'b1;
          foreach (seen[j]) if (seen[j][i] == mDeb[i]) allDiff = 1'b0;
          if (allDiff) newDeb[i] = ~mDeb[i];
        end
      end
      mDeb = newDeb;
      mS2  = mS1;
      mS1  = bus.btn;
    end
  end

  // ------------------------------------------------------------------
  // Checking helpers
  // ------------------------------------------------------------------
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle outside reset, compare the DUT against the model.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("cmpPlayerNum",     int'(bus.playerNum),     int'(expNum));
      checkOutput("cmpPlayerPressed", int'(bus.playerPressed), int'(expPressed));
      checkOutput("cmpPressEvent",    int'(bus.pressEvent),    int'(expEvent));
      checkOutput("cmpMultiPress",    int'(bus.multiPress),    int'(expMulti));
    end
  end

  // Drive the inputs on a falling edge so they are stable at the next
  // rising edge.
  task automatic applyStimulus(input logic [3:0] b, input logic t);
    @(negedge clk);
    bus.btn       = b;
    bus.simonTurn = t;
  endtask

  // Count rising edges (from the current falling edge) until the selected
  // output reaches the given level; a missing transition shows up as 40.
  task automatic measureEdges(input string name, input int sel, input logic level,
                              input int expected);
    int   n;
    logic v;
    n = 0;
    v = ~level;
    while (v !== level && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      v = (sel == 0) ? bus.playerPressed : bus.multiPress;
    end
    checkOutput(name, n, expected);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ------------------------------------------------------------------
  // Directed sequences
  // ------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.btn = 4'b0000;
    bus.simonTurn = 1'b0;

    #12;
    checkOutput("resetPlayerNum",     int'(bus.playerNum),     0);
    checkOutput("resetPlayerPressed", int'(bus.playerPressed), 0);
    checkOutput("resetPressEvent",    int'(bus.pressEvent),    0);
    checkOutput("resetMultiPress",    int'(bus.multiPress),    0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: clean press of colour 2 and release
    $display("[TB] sequence 1: clean press");
    applyStimulus(4'b0100, 1'b0);
    measureEdges("t1PressLatency", 0, 1'b1, DT + 3);
    checkOutput("t1PlayerNum", int'(bus.playerNum), 2);
    checkOutput("t1EventHigh", int'(bus.pressEvent), 1);
    @(posedge clk); #1;
    checkOutput("t1EventLow", int'(bus.pressEvent), 0);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t1ReleaseLatency", 0, 1'b0, DT + 3);
    checkOutput("t1NumHeld", int'(bus.playerNum), 2);

    // 2: bouncing button 1
    $display("[TB] sequence 2: bounce");
    repeat (4) @(negedge clk);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    measureEdges("t2PressLatency", 0, 1'b1, DT + 3);
    checkOutput("t2PlayerNum", int'(bus.playerNum), 1);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t2ReleaseLatency", 0, 1'b0, DT + 3);

    // 3: multi-press rejected, then a single press accepted
    $display("[TB] sequence 3: multi-press");
    repeat (4) @(negedge clk);
    applyStimulus(4'b1001, 1'b0);
    measureEdges("t3RejectLatency", 1, 1'b1, DT + 3);
    checkOutput("t3NoPress", int'(bus.playerPressed), 0);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t3RejectClear", 1, 1'b0, DT + 3);
    repeat (2) @(negedge clk);
    applyStimulus(4'b1000, 1'b0);
    measureEdges("t3PressLatency", 0, 1'b1, DT + 3);
    checkOutput("t3PlayerNum", int'(bus.playerNum), 3);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t3Release", 0, 1'b0, DT + 3);

    // 4: lockout while Simon plays
    $display("[TB] sequence 4: lockout");
    repeat (4) @(negedge clk);
    applyStimulus(4'b0001, 1'b1);
    measureEdges("t4LockReject", 1, 1'b1, DT + 3);
    checkOutput("t4NoPress", int'(bus.playerPressed), 0);
    applyStimulus(4'b0001, 1'b0);
    repeat (8) @(negedge clk);
    checkOutput("t4StillNoPress", int'(bus.playerPressed), 0);
    checkOutput("t4StillReject",  int'(bus.multiPress),    1);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t4RejectClear", 1, 1'b0, DT + 3);
    repeat (2) @(negedge clk);
    applyStimulus(4'b0001, 1'b0);
    measureEdges("t4PressLatency", 0, 1'b1, DT + 3);
    checkOutput("t4PlayerNum", int'(bus.playerNum), 0);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t4Release", 0, 1'b0, DT + 3);

    // 5: lockout raised during a held press; release while locked out
    $display("[TB] sequence 5: lockout during press");
    repeat (4) @(negedge clk);
    applyStimulus(4'b1000, 1'b0);
    measureEdges("t5PressLatency", 0, 1'b1, DT + 3);
    repeat (2) @(negedge clk);
    applyStimulus(4'b1000, 1'b1);
    measureEdges("t5LockDrop", 0, 1'b0, 1);
    checkOutput("t5MultiPress", int'(bus.multiPress), 1);
    applyStimulus(4'b0000, 1'b1);
    measureEdges("t5IdleDespiteTurn", 1, 1'b0, DT + 3);
    applyStimulus(4'b0000, 1'b0);

    // 5b: button settles on the same cycle simonTurn rises
    $display("[TB] sequence 5b: simultaneous lockout");
    repeat (4) @(negedge clk);
    applyStimulus(4'b0010, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(4'b0010, 1'b1);
    measureEdges("t5bLockWins", 1, 1'b1, 1);
    checkOutput("t5bNoPress", int'(bus.playerPressed), 0);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t5bClear", 1, 1'b0, DT + 3);

    // 6: asynchronous reset in the middle of a held press
    $display("[TB] sequence 6: reset mid-press");
    repeat (4) @(negedge clk);
    applyStimulus(4'b1000, 1'b0);
    measureEdges("t6PressLatency", 0, 1'b1, DT + 3);
    checkOutput("t6PlayerNum", int'(bus.playerNum), 3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6AsyncPressed", int'(bus.playerPressed), 0);
    checkOutput("t6AsyncNum",     int'(bus.playerNum),     0);
    checkOutput("t6AsyncEvent",   int'(bus.pressEvent),    0);
    checkOutput("t6AsyncMulti",   int'(bus.multiPress),    0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    measureEdges("t6Repress", 0, 1'b1, DT + 3);
    checkOutput("t6RepressNum",   int'(bus.playerNum),  3);
    checkOutput("t6RepressEvent", int'(bus.pressEvent), 1);
    applyStimulus(4'b0000, 1'b0);
    measureEdges("t6Release", 0, 1'b0, DT + 3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
